run_controller: RTL and testbench

- Parametrised run-control block that sits between the testbench/top level and the processor core (`main`).
- Generalises the fixed "pulse reset, toggle clock N times, finish" sequence into reusable hardware:
  - programmable core-reset hold length;
  - free-run and single-step modes;
  - retired-instruction and cycle counters;
  - halt and timeout detection.
- Drives the core's reset and enable; reports status to the bench or a debug port.

---
 rtl/run_controller.sv | 121 ++++++++++++
 tb/tb_run_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Run-control sequencer for the processor core: holds core reset after start,
// then gates the core clock-enable in free-run or single-step mode until halt or budget expiry.
module run_controller #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             halt_req,
  input  logic             retire,
  output logic             core_reset,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  BUDGET    = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  cycle_inc;
  logic [CNT_W-1:0]  instr_inc;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  always_comb begin
    cycle_inc = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + CNT_W'(1);
    instr_inc = (instr_count == CNT_MAX) ? instr_count : instr_count + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      core_reset  <= 1'b1;
      core_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_HOLD;
            core_reset  <= 1'b1;
            core_en     <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
            hold_cnt    <= '0;
          end
        end

        // Step pulses seen during the hold are dropped; only the mode picks the first RUN cycle.
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
            core_en    <= ~step_mode;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        S_RUN: begin
          if (core_en) begin
            cycle_count <= cycle_inc;
            if (retire) begin
              instr_count <= instr_inc;
            end
          end
          // Halt outranks budget expiry when both land on the same enabled cycle.
          if (core_en && halt_req) begin
            state   <= S_DONE;
            core_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b0;
          end else if (core_en && (cycle_inc == BUDGET)) begin
            state   <= S_DONE;
            core_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            core_en <= ~step_mode | step;
          end
        end

        default: begin
          state      <= S_IDLE;
          core_reset <= 1'b1;
          core_en    <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: two instances (default budget, and an 8-cycle budget),
// directed scenarios plus randomized runs checked against a cycle-level reference of the run rules.
module tb_run_controller;

  localparam int unsigned CW = 16;
  localparam int NC = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, start, smode, stp, halt, ret;
  logic [1:0] core_reset, core_en, busy, done, timeout;
  logic [1:0][CW-1:0] cyc_cnt, ins_cnt;

  run_controller #(.RESET_CYCLES(2), .MAX_CYCLES(1000), .CNT_W(CW)) dut_a (
    .Clk(clk), .Reset(rst[0]), .start(start[0]), .step_mode(smode[0]), .step(stp[0]),
    .halt_req(halt[0]), .retire(ret[0]), .core_reset(core_reset[0]), .core_en(core_en[0]),
    .busy(busy[0]), .done(done[0]), .timeout(timeout[0]),
    .cycle_count(cyc_cnt[0]), .instr_count(ins_cnt[0])
  );

  run_controller #(.RESET_CYCLES(3), .MAX_CYCLES(8), .CNT_W(CW)) dut_b (
    .Clk(clk), .Reset(rst[1]), .start(start[1]), .step_mode(smode[1]), .step(stp[1]),
    .halt_req(halt[1]), .retire(ret[1]), .core_reset(core_reset[1]), .core_en(core_en[1]),
    .busy(busy[1]), .done(done[1]), .timeout(timeout[1]),
    .cycle_count(cyc_cnt[1]), .instr_count(ins_cnt[1])
  );

  typedef struct packed {
    logic        to;
    logic [31:0] cnt;
    logic [31:0] ins;
    logic [31:0] at;
  } done_t;

  done_t dq0[$], dq1[$];
  bit    enq0[$], enq1[$];

  bit sm_v[NC], st_v[NC], hr_v[NC], rt_v[NC];

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cyc_n, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever a DUT shows a RUN cycle or a fresh done.
  int hold_len[2];
  logic [1:0] done_prev = 2'bxx;

  task automatic mon(input int d);
    bit e;
    done_t x;
    bit empty;
    if (busy[d] === 1'b1 && core_reset[d] === 1'b0) begin
      empty = (d == 0) ? (enq0.size() == 0) : (enq1.size() == 0);
      if (empty) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_run dut%0d cycle %0d: got run cycle expected none", d, cyc_n);
      end else begin
        if (d == 0) e = enq0.pop_front(); else e = enq1.pop_front();
        check("core_en", d, 64'(core_en[d]), 64'(e));
      end
    end
    if (busy[d] === 1'b1 && core_reset[d] === 1'b1) begin
      hold_len[d]++;
    end else if (hold_len[d] != 0) begin
      check("hold_len", d, 64'(hold_len[d]), (d == 0) ? 64'd2 : 64'd3);
      hold_len[d] = 0;
    end
    if (done[d] === 1'b1 && done_prev[d] !== 1'b1) begin
      empty = (d == 0) ? (dq0.size() == 0) : (dq1.size() == 0);
      if (empty) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done dut%0d cycle %0d: got done expected none", d, cyc_n);
      end else begin
        if (d == 0) x = dq0.pop_front(); else x = dq1.pop_front();
        check("done_at", d, 64'(cyc_n), 64'(x.at));
        check("timeout", d, 64'(timeout[d]), 64'(x.to));
        check("cycle_count", d, 64'(cyc_cnt[d]), 64'(x.cnt));
        check("instr_count", d, 64'(ins_cnt[d]), 64'(x.ins));
      end
    end
    done_prev[d] = done[d];
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic clear_vecs();
    for (int r = 0; r < NC; r++) begin
      sm_v[r] = 0; st_v[r] = 0; hr_v[r] = 0; rt_v[r] = 0;
    end
  endtask

  // Random activity for k cycles, then free-run (with halt on the big-budget unit) so every run ends.
  task automatic rand_vecs(input int d, input int k);
    for (int r = 0; r < NC; r++) begin
      rt_v[r] = 1'($urandom_range(0, 1));
      if (r < k) begin
        sm_v[r] = 1'($urandom_range(0, 1));
        st_v[r] = ($urandom_range(0, 2) == 0);
        hr_v[r] = ($urandom_range(0, 7) == 0);
      end else begin
        sm_v[r] = 0;
        st_v[r] = 0;
        hr_v[r] = (d == 0);
      end
    end
  endtask

  task automatic check_idle(input int d);
    check("rst_core_reset", d, 64'(core_reset[d]), 64'd1);
    check("rst_core_en", d, 64'(core_en[d]), 64'd0);
    check("rst_busy", d, 64'(busy[d]), 64'd0);
    check("rst_done", d, 64'(done[d]), 64'd0);
    check("rst_timeout", d, 64'(timeout[d]), 64'd0);
    check("rst_cycle_count", d, 64'(cyc_cnt[d]), 64'd0);
    check("rst_instr_count", d, 64'(ins_cnt[d]), 64'd0);
  endtask

  // One run: reference computes the enabled-cycle sequence and outcome, then inputs are applied.
  task automatic do_run(input int d, input int probe_r, input int probe_v, input int abort_r);
    int R, M, s, cnt, ins, done_r, last, stop_r;
    bit to, en, aborting;
    done_t x;
    R = (d == 0) ? 2 : 3;
    M = (d == 0) ? 1000 : 8;
    @(posedge clk); #1;
    s = int'(cyc_n);
    cnt = 0; ins = 0; done_r = -1; to = 0;
    for (int r = R + 1; r < NC; r++) begin
      if (abort_r >= 0 && r > abort_r) break;
      if (r == R + 1) en = !sm_v[r-1];
      else            en = !sm_v[r-1] || st_v[r-1];
      if (d == 0) enq0.push_back(en); else enq1.push_back(en);
      if (en) begin
        cnt++;
        if (rt_v[r]) ins++;
      end
      if (en && hr_v[r]) begin done_r = r; break; end
      if (cnt == M) begin done_r = r; to = 1; break; end
    end
    aborting = (abort_r >= 0) && (done_r < 0);
    if (!aborting && done_r >= 0) begin
      x.to = to; x.cnt = 32'(cnt); x.ins = 32'(ins); x.at = 32'(s + done_r + 1);
      if (d == 0) dq0.push_back(x); else dq1.push_back(x);
    end
    last   = aborting ? abort_r : ((done_r >= 0) ? done_r + 3 : NC - 1);
    stop_r = aborting ? abort_r - 1 : done_r;
    for (int r = 0; r <= last; r++) begin
      if (r > 0) begin @(posedge clk); #1; end
      start[d] = (r == 0) || (r >= 1 && r <= stop_r && $urandom_range(0, 7) == 0);
      smode[d] = (r < NC) ? sm_v[r] : 1'b0;
      stp[d]   = (r < NC) ? st_v[r] : 1'b0;
      halt[d]  = (r < NC) ? hr_v[r] : 1'b0;
      ret[d]   = (r < NC) ? rt_v[r] : 1'b0;
      rst[d]   = aborting && (r == abort_r);
      @(negedge clk);
      if (r == 1) begin
        check("hold_busy", d, 64'(busy[d]), 64'd1);
        check("hold_core_reset", d, 64'(core_reset[d]), 64'd1);
        check("hold_cleared_cycles", d, 64'(cyc_cnt[d]), 64'd0);
        check("hold_cleared_instrs", d, 64'(ins_cnt[d]), 64'd0);
        check("hold_cleared_timeout", d, 64'(timeout[d]), 64'd0);
      end
      if (r == probe_r) check("probe_cycle_count", d, 64'(cyc_cnt[d]), 64'(probe_v));
      if (!aborting && r == last) begin
        check("frozen_done", d, 64'(done[d]), 64'd1);
        check("frozen_core_reset", d, 64'(core_reset[d]), 64'd0);
        check("frozen_cycle_count", d, 64'(cyc_cnt[d]), 64'(cnt));
        check("frozen_instr_count", d, 64'(ins_cnt[d]), 64'(ins));
      end
    end
    @(posedge clk); #1;
    start[d] = 0; smode[d] = 0; stp[d] = 0; halt[d] = 0; ret[d] = 0; rst[d] = 0;
    if (aborting) begin
      @(negedge clk);
      check_idle(d);
    end
  endtask

  initial begin
    int d;
    rst = 2'b11; start = '0; smode = '0; stp = '0; halt = '0; ret = '0;
    hold_len[0] = 0; hold_len[1] = 0;
    clear_vecs();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_idle(i);
    rst = '0;

    // Default unit: retire every cycle, halt on the 10th enabled cycle.
    clear_vecs();
    for (int r = 0; r < NC; r++) rt_v[r] = 1;
    hr_v[12] = 1;
    do_run(0, -1, 0, -1);
    check("plan_halt_done", 0, 64'(done[0]), 64'd1);
    check("plan_halt_timeout", 0, 64'(timeout[0]), 64'd0);
    check("plan_halt_cycles", 0, 64'(cyc_cnt[0]), 64'd10);
    check("plan_halt_instrs", 0, 64'(ins_cnt[0]), 64'd10);

    // Small-budget unit: no halt, expires after 8 enabled cycles and stays frozen.
    clear_vecs();
    for (int r = 0; r < NC; r++) rt_v[r] = 1;
    do_run(1, -1, 0, -1);
    check("plan_budget_timeout", 1, 64'(timeout[1]), 64'd1);
    check("plan_budget_cycles", 1, 64'(cyc_cnt[1]), 64'd8);
    repeat (5) @(posedge clk);
    #1;
    check("plan_budget_frozen", 1, 64'(cyc_cnt[1]), 64'd8);

    // Single-step: three spaced pulses, a halt while disabled, then free-run to budget.
    clear_vecs();
    for (int r = 0; r < 20; r++) sm_v[r] = 1;
    st_v[4] = 1; st_v[8] = 1; st_v[12] = 1;
    hr_v[6] = 1;
    for (int r = 0; r < NC; r++) rt_v[r] = 1'($urandom_range(0, 1));
    do_run(1, 16, 3, -1);

    // Reset asserted on the 5th RUN cycle of the default unit.
    clear_vecs();
    for (int r = 0; r < NC; r++) rt_v[r] = 1;
    do_run(0, -1, 0, 7);

    // Restart from DONE with halt and budget expiry on the same enabled cycle.
    clear_vecs();
    for (int r = 0; r < NC; r++) rt_v[r] = 1'($urandom_range(0, 1));
    hr_v[11] = 1;
    do_run(1, -1, 0, -1);
    check("plan_tie_done", 1, 64'(done[1]), 64'd1);
    check("plan_tie_timeout", 1, 64'(timeout[1]), 64'd0);
    check("plan_tie_cycles", 1, 64'(cyc_cnt[1]), 64'd8);

    for (int i = 0; i < 30; i++) begin
      d = int'($urandom_range(0, 1));
      rand_vecs(d, int'($urandom_range(5, 40)));
      do_run(d, -1, 0, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("leftover_en", 0, 64'(enq0.size() + enq1.size()), 64'd0);
    check("leftover_done", 0, 64'(dq0.size() + dq1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
